// File: rtl/detect_pkg.sv
// Shared constants for the 000/111 run detector and its rate monitor.
package detect_pkg;

    // Rate monitor FSM: idle, or counting samples inside a window.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } mon_state_e;

    // Run detector FSM: tracks the length of the current 0-run or 1-run.
    typedef enum logic [2:0] {
        DET_START = 3'd0,
        DET_Z1    = 3'd1,
        DET_Z2    = 3'd2,
        DET_O1    = 3'd3,
        DET_O2    = 3'd4
    } det_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    // Clear has priority over increment; increment stops at MAX_VAL.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != MAX_VAL)) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/detect_rate_monitor.sv
// Counts detector hits over back-to-back windows of WINDOW cycles, publishes
// each window's count and raises a sticky alarm when a count reaches THRESH.
module detect_rate_monitor
    import detect_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int THRESH = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             det_in,
    input  logic             clear,
    output logic             win_done,
    output logic [CNT_W-1:0] last_count,
    output logic             alarm
);

    localparam int               WCNT_W   = $clog2(WINDOW);
    localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  HITS_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  THRESH_C = CNT_W'(THRESH);

    mon_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  hits;
    logic              hit_clr, hit_inc;
    logic              win_done_q, win_done_d;
    logic [CNT_W-1:0]  last_count_q, last_count_d;
    logic              alarm_q, alarm_d;
    logic [CNT_W-1:0]  final_count;
    logic              trip;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_hits (
        .clk   (clk),
        .reset (reset),
        .clr   (hit_clr),
        .inc   (hit_inc),
        .q     (hits)
    );

    // Next-state logic: window sequencing, hit counter control and alarm.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        hit_clr      = 1'b0;
        hit_inc      = 1'b0;
        win_done_d   = 1'b0;
        last_count_d = last_count_q;
        trip         = 1'b0;
        // Count including the current sample, since the final sample never
        // reaches the counter before the window is published.
        final_count  = (det_in && (hits != HITS_MAX)) ? hits + CNT_W'(1) : hits;

        case (state_q)
            IDLE: begin
                hit_clr = 1'b1;
                wcnt_d  = '0;
                if (enable) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!enable) begin
                    // Abandon the partial window; outputs keep their values.
                    state_d = IDLE;
                    wcnt_d  = '0;
                    hit_clr = 1'b1;
                end else if (wcnt_q == WIN_LAST) begin
                    last_count_d = final_count;
                    win_done_d   = 1'b1;
                    trip         = (final_count >= THRESH_C);
                    wcnt_d       = '0;
                    hit_clr      = 1'b1;
                end else begin
                    wcnt_d  = wcnt_q + WCNT_W'(1);
                    hit_inc = det_in;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A trip in the same cycle beats a clear request.
        if (trip) begin
            alarm_d = 1'b1;
        end else if (clear) begin
            alarm_d = 1'b0;
        end else begin
            alarm_d = alarm_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            win_done_q   <= 1'b0;
            last_count_q <= '0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            win_done_q   <= win_done_d;
            last_count_q <= last_count_d;
            alarm_q      <= alarm_d;
        end
    end

    assign win_done   = win_done_q;
    assign last_count = last_count_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_detect_rate_monitor.sv
// Directed checks of detect_rate_monitor: main instance WINDOW=8/THRESH=3,
// plus a narrow-counter instance to exercise saturation.
module tb_detect_rate_monitor;

    logic       clk = 1'b0;
    logic       reset, enable, det_in, clear;
    logic       win_done;
    logic [7:0] last_count;
    logic       alarm;

    logic       reset2, enable2, det_in2, clear2;
    logic       win_done2;
    logic [2:0] last_count2;
    logic       alarm2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    detect_rate_monitor #(
        .WINDOW (8),
        .THRESH (3),
        .CNT_W  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .det_in     (det_in),
        .clear      (clear),
        .win_done   (win_done),
        .last_count (last_count),
        .alarm      (alarm)
    );

    detect_rate_monitor #(
        .WINDOW (16),
        .THRESH (4),
        .CNT_W  (3)
    ) dut_sat (
        .clk        (clk),
        .reset      (reset2),
        .enable     (enable2),
        .det_in     (det_in2),
        .clear      (clear2),
        .win_done   (win_done2),
        .last_count (last_count2),
        .alarm      (alarm2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic en, input logic d, input logic cl);
        enable = en;
        det_in = d;
        clear  = cl;
        tick();
    endtask

    // Run one full window (sample s takes det_in = pattern[s]) and check
    // that win_done appears only after the eighth sample.
    task automatic run_window(input string tag, input logic [7:0] pattern,
                              input logic clr_last, input logic [7:0] exp_cnt,
                              input logic exp_alarm);
        for (int s = 0; s < 8; s++) begin
            cyc(1'b1, pattern[s], clr_last && (s == 7));
            if (s < 7) begin
                chk({tag, "_nodone"}, 32'(win_done), 32'd0);
            end
        end
        chk({tag, "_done"}, 32'(win_done), 32'd1);
        chk({tag, "_count"}, 32'(last_count), 32'(exp_cnt));
        chk({tag, "_alarm"}, 32'(alarm), 32'(exp_alarm));
        $display("window %s pattern=%b count=%0d alarm=%0d", tag, pattern, last_count, alarm);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; det_in = 1'b0; clear = 1'b0;
        reset2 = 1'b1; enable2 = 1'b0; det_in2 = 1'b0; clear2 = 1'b0;
        tick();
        tick();
        chk("rst_done", 32'(win_done), 32'd0);
        chk("rst_count", 32'(last_count), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        reset = 1'b0;

        // Idle with enable low; det_in toggling must be ignored.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, i[0], 1'b0);
            chk("idle_done", 32'(win_done), 32'd0);
            chk("idle_count", 32'(last_count), 32'd0);
            chk("idle_alarm", 32'(alarm), 32'd0);
        end
        $display("idle 20 cycles done");

        // Enter COUNT, then windows back to back with no gap.
        cyc(1'b1, 1'b0, 1'b0);
        run_window("wA", 8'b0010_0100, 1'b0, 8'd2, 1'b0);
        run_window("wB", 8'b1000_0011, 1'b0, 8'd3, 1'b1);
        run_window("wC", 8'b0000_0000, 1'b0, 8'd0, 1'b1);
        // Clear coincides with a trip (4 hits): the trip wins.
        run_window("wD", 8'b0000_1111, 1'b1, 8'd4, 1'b1);

        // Next window: lone clear two cycles after the previous one.
        cyc(1'b1, 1'b0, 1'b0);
        chk("wE_s0_alarm", 32'(alarm), 32'd1);
        chk("wE_s0_done", 32'(win_done), 32'd0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("wE_clear_alarm", 32'(alarm), 32'd0);
        $display("lone clear: alarm=%0d", alarm);
        for (int s = 2; s < 5; s++) cyc(1'b1, 1'b0, 1'b0);

        // Drop enable at wcnt=5: partial window discarded.
        cyc(1'b0, 1'b1, 1'b0);
        chk("drop_done", 32'(win_done), 32'd0);
        chk("drop_count", 32'(last_count), 32'd4);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            chk("drop_idle_done", 32'(win_done), 32'd0);
        end
        $display("enable dropped mid-window: count=%0d", last_count);

        // Re-enable: a full eight samples before the next win_done.
        cyc(1'b1, 1'b1, 1'b0);
        chk("reen_done", 32'(win_done), 32'd0);
        run_window("wF", 8'b1111_1111, 1'b0, 8'd8, 1'b1);

        // Clear honoured in IDLE; last_count unaffected.
        cyc(1'b0, 1'b0, 1'b0);
        chk("idle_hold_alarm", 32'(alarm), 32'd1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("idle_clear_alarm", 32'(alarm), 32'd0);
        chk("idle_clear_count", 32'(last_count), 32'd8);
        $display("clear in idle: alarm=%0d count=%0d", alarm, last_count);

        // Re-arm the alarm, then reset at wcnt=4.
        cyc(1'b1, 1'b0, 1'b0);
        run_window("wG", 8'b0000_0111, 1'b0, 8'd3, 1'b1);
        for (int s = 0; s < 4; s++) cyc(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        chk("midrst_done", 32'(win_done), 32'd0);
        chk("midrst_count", 32'(last_count), 32'd0);
        chk("midrst_alarm", 32'(alarm), 32'd0);
        $display("reset mid-window: done=%0d count=%0d alarm=%0d", win_done, last_count, alarm);
        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        run_window("wH", 8'b0100_0000, 1'b0, 8'd1, 1'b0);

        // Saturation: 3-bit counter, 16 hits in a 16-cycle window.
        reset2  = 1'b0;
        enable2 = 1'b1;
        det_in2 = 1'b1;
        tick();
        for (int s = 0; s < 16; s++) begin
            tick();
            if (s < 15) chk("sat_nodone", 32'(win_done2), 32'd0);
        end
        chk("sat_done", 32'(win_done2), 32'd1);
        chk("sat_count", 32'(last_count2), 32'd7);
        chk("sat_alarm", 32'(alarm2), 32'd1);
        $display("saturating window: count=%0d alarm=%0d", last_count2, alarm2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/detect_rate_monitor.md
DETECT_RATE_MONITOR -- requirements
Module: detect_rate_monitor

Interface
REQ-001 Parameter WINDOW, default 16: window length in clk cycles, allowed range 2 to 1024.
REQ-002 Parameter THRESH, default 4: hit count at which the alarm trips, allowed range 1 to 2^CNT_W-1.
REQ-003 Parameter CNT_W, default 8: width of the hit counter and of last_count.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 enable  input  1: level; high runs the monitor, low idles it.
REQ-007 det_in  input  1: per-cycle detect flag from the 000/111 run detector (its y output).
REQ-008 clear  input  1: single-cycle request to drop the sticky alarm.
REQ-009 win_done  output  1: one-cycle pulse when a window has been evaluated.
REQ-010 last_count  output  CNT_W: hit count of the most recently completed window.
REQ-011 alarm  output  1: sticky flag, set when a window's hit count is at least THRESH.

Function
REQ-012 FSM states SHALL be IDLE and COUNT; alarm SHALL be a separate register outside the FSM.
REQ-013 IDLE: det_in ignored; with enable=1 the next state SHALL be COUNT and wcnt and hits SHALL be set to 0.
REQ-014 COUNT, each cycle: wcnt increments; when det_in=1, hits increments, saturating at 2^CNT_W-1.
REQ-015 COUNT cycle with wcnt=WINDOW-1 (the window's final sample):
  - last_count <= sat(hits+det_in)
  - win_done <= 1 for exactly one cycle
  - wcnt and hits <= 0
  - the next window SHALL start with no gap cycles.
REQ-016 That same final cycle SHALL set alarm <= 1 when sat(hits+det_in) >= THRESH; alarm and win_done SHALL rise on the same edge.
REQ-017 Output latency SHALL be 1 cycle: the final sample of window N is visible on last_count, win_done and alarm on the following cycle.
REQ-018 clear=1 SHALL set alarm <= 0, except when the same cycle trips per REQ-016, in which case the trip wins and alarm stays 1.
REQ-019 clear SHALL be honoured in both FSM states and SHALL NOT affect wcnt, hits or last_count.
REQ-020 enable=0 in COUNT:
  - next state IDLE
  - the current sample and the partial window are discarded
  - no win_done pulse
  - last_count and alarm hold.
REQ-021 A window SHALL contain exactly WINDOW samples; counter widths SHALL be $clog2(WINDOW) for wcnt and CNT_W for hits.
REQ-022 All outputs SHALL be driven directly from registers.

Reset
REQ-023 reset=1 SHALL force on the next edge, overriding all other inputs: state=IDLE, wcnt=0, hits=0, last_count=0, win_done=0, alarm=0.
REQ-024 A reset asserted mid-window SHALL discard the partial window with no win_done pulse.

Structure
REQ-025 State encoding constants (IDLE, COUNT) SHALL live in the shared package detect_pkg, alongside the detector's state constants.
REQ-026 The saturating hit counter SHALL be the single sub-module sat_counter (parameter WIDTH; ports clk, reset, clr, inc, q).
REQ-027 The block SHALL be instantiable directly on the detector's y output with no glue logic.

Verification (WINDOW=8, THRESH=3, CNT_W=8 unless noted)
REQ-028 Reset, then idle with enable=0 for 20 cycles -> win_done=0, last_count=0, alarm=0 throughout.
REQ-029 enable=1; det_in=1 on window samples 2 and 5 -> win_done pulses 1 cycle after sample 7, last_count=2, alarm=0; the next window starts immediately.
REQ-030 det_in=1 on samples 0, 1 and 7 -> last_count=3, alarm=1 on the same cycle as win_done; a following all-zero window gives last_count=0 and alarm still 1.
REQ-031 With alarm=1, clear on a window-final cycle whose hit count is 4 -> alarm stays 1; a lone clear two cycles later -> alarm=0.
REQ-032 CNT_W=3, WINDOW=16, det_in held at 1 -> last_count=7 (saturated), alarm=1.
REQ-033 enable dropped at wcnt=5 -> no win_done and last_count unchanged; enable re-raised -> a full 8 samples before the next win_done; reset at wcnt=4 -> all outputs 0 on the next cycle.
